mem_access_stage: RTL

Memory stage directly downstream of the S/L-type execute stage. Consumes its address, store data, write-enable and mem_op outputs, and runs one data-bus transaction per load/store through a request/ready handshake. Applies byte-lane steering and load sign/zero extension, then presents write-back data to the register file. Stalls upstream while a bus access is outstanding.

---
 rtl/mem_access_stage_pkg.sv | 50 +++++
 rtl/mem_lane_align.sv | 43 ++++
 rtl/mem_access_stage.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared opcodes, FSM states and decode helpers for the memory access stage.
// The optional bus timeout is enabled by defining MEM_TIMEOUT_EN.
package mem_access_stage_pkg;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        LB      = 4'd1,
        LH      = 4'd2,
        LW      = 4'd3,
        LBU     = 4'd4,
        LHU     = 4'd5,
        SB      = 4'd6,
        SH      = 4'd7,
        SW      = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic [31:0] ZERO          = 32'h0000_0000;

    function automatic logic is_load(input logic [3:0] op);
        case (op)
            LB, LH, LW, LBU, LHU: return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        case (op)
            SB, SH, SW: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    // Byte ops can never be misaligned; halves need addr[0]=0, words addr[1:0]=0.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
        case (op)
            LH, LHU, SH: return addr_lo[0];
            LW, SW:      return |addr_lo;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte enables and lane-replicated
// store data, plus load byte/half extraction with sign or zero extension.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [3:0]  mem_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = load_word[{addr_lo, 3'b000} +: 8];
    assign half_sel = load_word[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        byte_en     = 4'b0000;
        store_lanes = store_data;
        load_data   = load_word;
        case (mem_op)
            SB: begin
                byte_en     = 4'b0001 << addr_lo;
                store_lanes = {4{store_data[7:0]}};
            end
            SH: begin
                byte_en     = 4'b0011 << {addr_lo[1], 1'b0};
                store_lanes = {2{store_data[15:0]}};
            end
            SW:  byte_en   = 4'b1111;
            LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            LBU: load_data = {24'h000000, byte_sel};
            LH:  load_data = {{16{half_sel[15]}}, half_sel};
            LHU: load_data = {16'h0000, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: one request/ready bus transaction per load/store, then one
// cycle of write-back. Define MEM_TIMEOUT_EN to abort stuck accesses (bus_err_o).
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
`ifdef MEM_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_we_i,
    input  logic [3:0]            mem_op_i,
    input  logic                  reg_we_i,
    input  logic [4:0]            reg_waddr_i,
    input  logic [DATA_WIDTH-1:0] reg_wdata_i,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [DATA_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    output logic [3:0]            bus_be_o,
    input  logic                  bus_ready_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    output logic                  reg_we_o,
    output logic [4:0]            reg_waddr_o,
    output logic [DATA_WIDTH-1:0] reg_wdata_o,
    output logic                  stall_o,
    output logic                  misalign_o
`ifdef MEM_TIMEOUT_EN
    , output logic                bus_err_o
`endif
);

    state_e      state;
    logic [3:0]  op_q;
    logic [1:0]  addr_lo_q;
    logic [4:0]  waddr_q;
    logic        op_valid;
    logic        op_misaligned;
    logic [3:0]  lane_op;
    logic [1:0]  lane_addr;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;
`ifdef MEM_TIMEOUT_EN
    logic [7:0]  timer;
`endif

    assign op_valid      = is_load(mem_op_i) || is_store(mem_op_i);
    assign op_misaligned = is_misaligned(mem_op_i, mem_addr_i[1:0]);

    // One lane aligner serves both directions: live inputs while IDLE decide
    // the store lanes, the captured op/offset decide load extraction later.
    assign lane_op   = (state == ST_IDLE) ? mem_op_i : op_q;
    assign lane_addr = (state == ST_IDLE) ? mem_addr_i[1:0] : addr_lo_q;

    mem_lane_align u_lane_align (
        .mem_op      (lane_op),
        .addr_lo     (lane_addr),
        .store_data  (mem_data_i),
        .load_word   (bus_rdata_i),
        .byte_en     (lane_be),
        .store_lanes (lane_wdata),
        .load_data   (lane_load)
    );

    assign stall_o = !rst_i &&
                     ((state == ST_ACCESS) ||
                      (state == ST_IDLE && op_valid && !op_misaligned));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            op_q        <= MEM_NOP;
            addr_lo_q   <= 2'b00;
            waddr_q     <= 5'd0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= ZERO;
            bus_wdata_o <= ZERO;
            bus_be_o    <= 4'b0000;
            reg_we_o    <= WRITE_DISABLE;
            reg_waddr_o <= 5'd0;
            reg_wdata_o <= ZERO;
            misalign_o  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            timer       <= 8'd0;
            bus_err_o   <= 1'b0;
`endif
        end else begin
            misalign_o <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            bus_err_o  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (!op_valid) begin
                        reg_we_o    <= reg_we_i;
                        reg_waddr_o <= reg_waddr_i;
                        reg_wdata_o <= reg_wdata_i;
                    end else if (op_misaligned) begin
                        misalign_o <= 1'b1;
                        reg_we_o   <= WRITE_DISABLE;
                    end else begin
                        op_q        <= mem_op_i;
                        addr_lo_q   <= mem_addr_i[1:0];
                        waddr_q     <= reg_waddr_i;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        bus_wdata_o <= lane_wdata;
                        bus_be_o    <= lane_be;
                        reg_we_o    <= WRITE_DISABLE;
                        state       <= ST_ACCESS;
`ifdef MEM_TIMEOUT_EN
                        timer       <= 8'd0;
`endif
                    end
                end
                ST_ACCESS: begin
                    if (bus_ready_i) begin
                        bus_req_o   <= 1'b0;
                        bus_we_o    <= 1'b0;
                        reg_we_o    <= is_load(op_q) ? WRITE_ENABLE : WRITE_DISABLE;
                        reg_waddr_o <= waddr_q;
                        reg_wdata_o <= is_load(op_q) ? lane_load : ZERO;
                        state       <= ST_RESP;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (timer == 8'(TIMEOUT_CYCLES - 1)) begin
                        bus_req_o <= 1'b0;
                        bus_we_o  <= 1'b0;
                        reg_we_o  <= WRITE_DISABLE;
                        bus_err_o <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        timer <= timer + 8'd1;
                    end
`endif
                end
                ST_RESP: begin
                    reg_we_o <= WRITE_DISABLE;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
